// File: rtl/mips_muldiv.sv
// Iterative MIPS-style multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with sign handling before and after the loop.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divz
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [W2-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_busy;
  logic             r_done;
  logic             r_divz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_is_div;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [W2-1:0]    w_mul_nxt;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [W2-1:0]    w_div_nxt;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign divz = r_divz;

  // op[0] selects unsigned, op[1] selects divide
  assign w_signed   = ~r_op[0];
  assign w_is_div   = r_op[1];
  assign w_div_zero = w_is_div && (r_b == {WIDTH{1'b0}});
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  assign w_abs_a = (w_signed && r_a[WIDTH-1]) ? (-r_a) : r_a;
  assign w_abs_b = (w_signed && r_b[WIDTH-1]) ? (-r_b) : r_b;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right
  assign w_addend  = r_acc[0] ? r_m : {WIDTH{1'b0}};
  assign w_sum     = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign w_shift   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_m});
  assign w_diff    = WIDTH'(w_shift - {1'b0, r_m});
  assign w_div_nxt = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_prod_fix = r_neg_lo ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg_lo ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? (-r_acc[W2-1:WIDTH]) : r_acc[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_PREP;
      S_PREP: w_state_nxt = w_div_zero ? S_FIX : S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_divz   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_a    <= opA;
            r_b    <= opB;
            r_busy <= 1'b1;
            r_divz <= 1'b0;
          end
        end
        S_PREP: begin
          r_cnt    <= '0;
          r_neg_lo <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_hi <= w_signed & r_a[WIDTH-1];
          if (w_is_div) begin
            r_m   <= w_abs_b;
            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            if (w_div_zero) r_divz <= 1'b1;
          end else begin
            r_m   <= w_abs_a;
            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
          end
        end
        S_RUN: begin
          r_cnt <= CW'(r_cnt + 1'b1);
          r_acc <= w_is_div ? w_div_nxt : w_mul_nxt;
        end
        S_FIX: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          if (r_divz) begin
            r_hi <= r_a;
            r_lo <= {WIDTH{1'b1}};
          end else if (w_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[W2-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: a 64-bit reference model queues expected
// hi/lo/divz at issue; a monitor pops and compares on each done pulse.
module tb_mips_muldiv;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         divz;

  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_err    = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .divz  (divz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    e.divz = 1'b0;
    e.hi   = '0;
    e.lo   = '0;
    case (o)
      2'b00: begin
        p    = 64'(sa * sbv);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p    = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          e.hi   = a;
          e.lo   = '1;
          e.divz = 1'b1;
        end else if (o == 2'b10) begin
          q    = sa / sbv;
          r    = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("divz", 64'(divz), 64'(e.divz));
        last = e;
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input bit poke);
    int n;
    int nbusy;
    int lat;
    if (!b2b) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    sb.push_back(model(o, a, b));
    lat = (o[1] && b == '0) ? 2 : W + 2;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    opA   = $urandom;
    opB   = $urandom;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_divz", 64'(divz), 64'(0));
    nbusy = 1;
    n     = 0;
    while (!done && n < 100) begin
      start = poke && (n == 5 || n == 20);
      @(posedge clk);
      #1;
      n++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(nbusy), 64'(lat));
    check("done_busy", 64'(busy), 64'(0));
  endtask

  task automatic check_hold();
    repeat (3) @(negedge clk);
    check("hold_hi", 64'(hi), 64'(last.hi));
    check("hold_lo", 64'(lo), 64'(last.lo));
    check("hold_divz", 64'(divz), 64'(last.divz));
    check("hold_done", 64'(done), 64'(0));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opA   = '0;
    opB   = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_divz", 64'(divz), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, with start pokes while busy on the first one
    run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b1);
    check_hold();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    check_hold();
    run_op(2'b00, 32'd2, 32'd3, 1'b0, 1'b0);

    // Back-to-back: start raised during the done cycle
    run_op(2'b11, 32'd1000, 32'd33, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FC18, 32'd7, 1'b1, 1'b0);
    run_op(2'b11, 32'd9, 32'd0, 1'b1, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 6 == 0) ? 32'd0 : ((i % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom);
      run_op(2'($urandom_range(0, 3)), a, b, (i % 2 == 1), (i % 4 == 0));
    end

    // Reset ten cycles into a multiply: operation abandoned, outputs cleared
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    opA   = 32'd123;
    opB   = 32'd456;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_divz", 64'(divz), 64'(0));
    repeat (3) @(negedge clk);
    check("midrst_hold_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    run_op(2'b01, 32'd12, 32'd13, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
